// File: rtl/sram_like_arbiter_if.sv
// Generic sram-like bus bundle: request/address phase plus in-order data response.
// The requester drives the master side; the responder drives the slave side.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic [31:0] rdata;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, rdata, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, rdata, data_ok
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave between the instruction and data requesters, routing in-order
// responses back through an ID FIFO and dropping instruction responses after a flush.
module sram_like_arbiter #(
    parameter int unsigned OUTSTANDING = 4,
    parameter int unsigned STARVE_MAX  = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    sram_like_arbiter_if.slave          inst_io,
    sram_like_arbiter_if.slave          data_io,
    sram_like_arbiter_if.master         slv_io,
    input  logic                        inst_cancel_i,
    output logic                        arb_busy_o
);
    localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(OUTSTANDING + 1);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [OUTSTANDING-1:0] id_q, id_d;
    logic [OUTSTANDING-1:0] drop_q, drop_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [SW-1:0]          starve_q, starve_d;

    logic full, force_inst, grant_inst, push, pop, head_id, head_drop;

    assign full       = (count_q == CW'(OUTSTANDING));
    assign force_inst = inst_io.req & (starve_q == SW'(STARVE_MAX));
    assign grant_inst = force_inst | (inst_io.req & ~data_io.req);

    assign slv_io.req   = (inst_io.req | data_io.req) & ~full;
    assign slv_io.wr    = grant_inst ? 1'b0 : data_io.wr;
    assign slv_io.size  = grant_inst ? inst_io.size : data_io.size;
    assign slv_io.addr  = grant_inst ? inst_io.addr : data_io.addr;
    assign slv_io.wdata = grant_inst ? 32'h0 : data_io.wdata;

    assign inst_io.addr_ok = slv_io.addr_ok & slv_io.req & grant_inst;
    assign data_io.addr_ok = slv_io.addr_ok & slv_io.req & ~grant_inst;

    assign push      = slv_io.req & slv_io.addr_ok;
    assign pop       = slv_io.data_ok & (count_q != '0);
    assign head_id   = id_q[rd_ptr_q];
    assign head_drop = drop_q[rd_ptr_q];

    // A cancel in the same cycle also hides the head instruction response.
    assign inst_io.data_ok = pop & head_id & ~head_drop & ~inst_cancel_i;
    assign data_io.data_ok = pop & ~head_id;
    assign inst_io.rdata   = slv_io.rdata;
    assign data_io.rdata   = slv_io.rdata;

    assign arb_busy_o = (count_q != '0);

    always_comb begin
        id_d     = id_q;
        drop_d   = inst_cancel_i ? (drop_q | id_q) : drop_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            id_d[wr_ptr_q]   = grant_inst;
            drop_d[wr_ptr_q] = inst_cancel_i & grant_inst;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);

        starve_d = starve_q;
        if (!inst_io.req || (push && grant_inst)) begin
            starve_d = '0;
        end else if (push && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            id_q     <= '0;
            drop_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            id_q     <= id_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed scenarios followed by random traffic, every cycle compared against a queue-based
// model of outstanding transactions and the starvation rule.
module tb_sram_like_arbiter;
    localparam int OUT = 4;
    localparam int SMAX = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, ir, dr, dwr, sok, sdok, cancel;
    logic [1:0]  isz, dsz;
    logic [31:0] iad, dad, dwd, srd;
    logic        busy;

    sram_like_arbiter_if ibus ();
    sram_like_arbiter_if dbus ();
    sram_like_arbiter_if sbus ();

    assign ibus.req     = ir;
    assign ibus.wr      = 1'b0;
    assign ibus.size    = isz;
    assign ibus.addr    = iad;
    assign ibus.wdata   = 32'h0;
    assign dbus.req     = dr;
    assign dbus.wr      = dwr;
    assign dbus.size    = dsz;
    assign dbus.addr    = dad;
    assign dbus.wdata   = dwd;
    assign sbus.addr_ok = sok;
    assign sbus.rdata   = srd;
    assign sbus.data_ok = sdok;

    sram_like_arbiter #(.OUTSTANDING(OUT), .STARVE_MAX(SMAX)) dut (
        .clk           (clk),
        .resetn        (rstn),
        .inst_io       (ibus),
        .data_io       (dbus),
        .slv_io        (sbus),
        .inst_cancel_i (cancel),
        .arb_busy_o    (busy)
    );

    typedef struct {bit is_inst; bit drop;} ent_t;
    ent_t q[$];
    int   m_starve;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rstn = 1'b1; ir = 0; dr = 0; dwr = 0; sok = 0; sdok = 0; cancel = 0;
        isz = 0; dsz = 0; iad = 0; dad = 0; dwd = 0; srd = 0;
    endtask

    // Check the current cycle against the model, advance the model, move to the next negedge.
    task automatic cycle();
        bit full, e_req, gi, push, pop, e_idok, e_ddok;
        #1;
        full   = (q.size() == OUT);
        e_req  = (ir || dr) && !full;
        gi     = (ir && m_starve == SMAX) || (ir && !dr);
        push   = e_req && sok;
        pop    = sdok && q.size() != 0;
        e_idok = pop && q[0].is_inst && !q[0].drop && !cancel;
        e_ddok = pop && !q[0].is_inst;
        chk("slv_req", 32'(sbus.req), 32'(e_req));
        chk("slv_wr", 32'(sbus.wr), gi ? 32'd0 : 32'(dwr));
        chk("slv_size", 32'(sbus.size), gi ? 32'(isz) : 32'(dsz));
        chk("slv_addr", sbus.addr, gi ? iad : dad);
        chk("slv_wdata", sbus.wdata, gi ? 32'd0 : dwd);
        chk("inst_addr_ok", 32'(ibus.addr_ok), 32'(push && gi));
        chk("data_addr_ok", 32'(dbus.addr_ok), 32'(push && !gi));
        chk("inst_data_ok", 32'(ibus.data_ok), 32'(e_idok));
        chk("data_data_ok", 32'(dbus.data_ok), 32'(e_ddok));
        if (e_idok) chk("inst_rdata", ibus.rdata, srd);
        if (e_ddok) chk("data_rdata", dbus.rdata, srd);
        chk("arb_busy", 32'(busy), 32'(q.size() != 0));
        if (!rstn) begin
            q.delete();
            m_starve = 0;
        end else begin
            if (cancel) foreach (q[i]) if (q[i].is_inst) q[i].drop = 1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{is_inst: gi, drop: cancel && gi});
            if (!ir || (push && gi)) m_starve = 0;
            else if (push && m_starve < SMAX) m_starve++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rstn = 0;
        cycle();
        idle();
    endtask

    initial begin
        idle(); rstn = 0;
        q.delete(); m_starve = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle();
        cycle();
        chk("reset_busy", 32'(busy), 32'd0);

        // T1 inst only
        ir = 1; iad = 32'hBFC00000; isz = 2; sok = 1;
        #1 chk("t1_addr_ok", 32'(ibus.addr_ok), 32'd1);
        cycle();
        idle(); cycle();
        sdok = 1; srd = 32'h3C1D0001;
        #1 chk("t1_data_ok", 32'(ibus.data_ok), 32'd1);
        chk("t1_rdata", ibus.rdata, 32'h3C1D0001);
        cycle();

        // T2 conflict: data first, then inst; responses in order
        idle(); ir = 1; iad = 32'h1000; dr = 1; dwr = 1; dad = 32'h2000; dwd = 32'hA5A5; sok = 1;
        #1 chk("t2_slv_addr", sbus.addr, 32'h2000);
        chk("t2_slv_wr", 32'(sbus.wr), 32'd1);
        cycle();
        dr = 0;
        #1 chk("t2_inst_grant", 32'(ibus.addr_ok), 32'd1);
        cycle();
        idle(); sdok = 1; srd = 32'h11;
        #1 chk("t2_resp_data", 32'(dbus.data_ok), 32'd1);
        cycle();
        srd = 32'h22;
        #1 chk("t2_resp_inst", 32'(ibus.data_ok), 32'd1);
        cycle();

        // T3 full
        idle(); ir = 1; sok = 1;
        for (int i = 0; i < 4; i++) begin iad = 32'h100 + 32'(i) * 4; cycle(); end
        #1 chk("t3_req_blocked", 32'(sbus.req), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        sdok = 1; cycle();
        sdok = 0;
        #1 chk("t3_push_after_pop", 32'(ibus.addr_ok), 32'd1);
        cycle();
        idle(); sdok = 1;
        repeat (5) cycle();

        // T4 cancel
        do_reset();
        ir = 1; sok = 1;
        repeat (3) cycle();
        idle(); cancel = 1; cycle();
        idle(); sdok = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_dropped", 32'(ibus.data_ok), 32'd0);
            cycle();
        end
        chk("t4_empty", 32'(busy), 32'd0);
        idle(); ir = 1; sok = 1; iad = 32'hBFC00010; cycle();
        idle(); sdok = 1;
        #1 chk("t4_refetch", 32'(ibus.data_ok), 32'd1);
        cycle();

        // T5 starvation
        do_reset();
        ir = 1; dr = 1; sok = 1; sdok = 1;
        for (int i = 0; i < SMAX; i++) begin
            #1 chk("t5_data_grant", 32'(dbus.addr_ok), 32'd1);
            cycle();
        end
        #1 chk("t5_forced_inst", 32'(ibus.addr_ok), 32'd1);
        cycle();
        #1 chk("t5_starve_cleared", 32'(dbus.addr_ok), 32'd1);
        cycle();
        idle(); sdok = 1; repeat (3) cycle();

        // T6 reset mid-flight
        idle(); ir = 1; sok = 1; repeat (2) cycle();
        do_reset();
        chk("t6_busy", 32'(busy), 32'd0);
        sdok = 1;
        #1 chk("t6_stale_inst", 32'(ibus.data_ok), 32'd0);
        chk("t6_stale_data", 32'(dbus.data_ok), 32'd0);
        cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rstn   = ($urandom_range(0, 199) != 0);
            ir     = $urandom_range(0, 1);
            dr     = $urandom_range(0, 1);
            dwr    = $urandom_range(0, 1);
            isz    = 2'($urandom_range(0, 2));
            dsz    = 2'($urandom_range(0, 2));
            iad    = $urandom;
            dad    = $urandom;
            dwd    = $urandom;
            srd    = $urandom;
            sok    = ($urandom_range(0, 3) != 0);
            sdok   = ($urandom_range(0, 2) != 0);
            cancel = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
